// File: rtl/seg7_pkg.sv
// Shared types and defaults for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    BLANK,
    SHOW
  } state_e;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_SCAN_DIV     = 10000;
  localparam int DEF_BLANK_CYCLES = 16;

  // Digit index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-slot cycle counter: blank_done marks the last blank cycle, slot_done the last lit cycle.
module seg7_slot_timer #(
  parameter int SCAN_DIV     = 10000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic blank_done_o,
  output logic slot_done_o
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] SLOT_LAST  = TW'(SCAN_DIV - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else            cnt_q <= cnt_q + 1'b1;
  end

  assign blank_done_o = (cnt_q == BLANK_LAST);
  assign slot_done_o  = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed digit scanner with double-buffered digit registers; new values are
// committed only at frame boundaries so a displayed frame is never torn.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int IDX_W       = idx_w(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [3:0]            wr_data,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_tick
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_e                         state_q;
  logic [IDX_W-1:0]               idx_q;
  logic [NUM_DIGITS-1:0]          sel_q;
  logic [3:0]                     code_q;
  logic                           tick_q;
  logic                           ready_q;
  logic                           run_q;
  logic [NUM_DIGITS-1:0][3:0]     shadow_q;
  logic [NUM_DIGITS-1:0][3:0]     active_q;

  logic                           blank_done, slot_done, tmr_clr;
  logic [IDX_W-1:0]               idx_d;
  logic [NUM_DIGITS-1:0]          sel_d;

  always_comb begin
    idx_d = idx_q + 1'b1;
    sel_d = NUM_DIGITS'(1) << idx_q;
  end

  // Timer only runs inside a slot; it is held at zero in IDLE and COMMIT.
  assign tmr_clr = !(enable && run_q && (state_q == BLANK || state_q == SHOW)) || slot_done;

  seg7_slot_timer #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (tmr_clr),
    .blank_done_o(blank_done),
    .slot_done_o (slot_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= '0;
    else if (wr_valid && ready_q) shadow_q[wr_addr] <= wr_data;
  end

  // Outputs are loaded with the values of the state being entered, so they line up
  // with state_q. run_q holds the FSM in IDLE for the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sel_q    <= '0;
      code_q   <= '0;
      tick_q   <= 1'b0;
      ready_q  <= 1'b0;
      run_q    <= 1'b0;
      active_q <= '0;
    end else begin
      run_q   <= 1'b1;
      tick_q  <= 1'b0;
      ready_q <= 1'b1;
      sel_q   <= '0;
      if (!enable || !run_q) begin
        state_q <= IDLE;
        idx_q   <= '0;
        code_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= COMMIT;
            tick_q  <= 1'b1;
            ready_q <= 1'b0;
            idx_q   <= '0;
            code_q  <= '0;
          end
          COMMIT: begin
            active_q <= shadow_q;
            state_q  <= BLANK;
            code_q   <= shadow_q[0];
          end
          BLANK: begin
            if (blank_done) begin
              state_q <= SHOW;
              sel_q   <= sel_d;
            end
          end
          SHOW: begin
            if (!slot_done) begin
              sel_q <= sel_d;
            end else if (idx_q == IDX_LAST) begin
              state_q <= COMMIT;
              tick_q  <= 1'b1;
              ready_q <= 1'b0;
              idx_q   <= '0;
              code_q  <= '0;
            end else begin
              state_q <= BLANK;
              idx_q   <= idx_d;
              code_q  <= active_q[idx_d];
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wr_ready   = ready_q;
  assign digit_code = code_q;
  assign digit_sel  = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: frame-position model plus directed literal checks.
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int S = 8;
  localparam int B = 2;
  localparam int FRAME = N * S + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] digit_code;
  logic [3:0] digit_sel;
  logic       frame_tick;

  int n_chk  = 0;
  int n_pass = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (S),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .digit_code(digit_code),
    .digit_sel (digit_sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: position inside the frame (0 = commit cycle, -1 = idle) plus both register files.
  int         m_pos;
  bit         m_set;
  logic [3:0] m_shadow[N];
  logic [3:0] m_active[N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= -1;
      m_set <= 1'b0;
      for (int i = 0; i < N; i++) begin
        m_shadow[i] <= 4'h0;
        m_active[i] <= 4'h0;
      end
    end else begin
      if (wr_valid && m_set && m_pos != 0) m_shadow[wr_addr] <= wr_data;
      if (m_pos == 0 && enable)
        for (int i = 0; i < N; i++) m_active[i] <= m_shadow[i];
      if (!m_set || !enable) m_pos <= -1;
      else if (m_pos < 0)    m_pos <= 0;
      else                   m_pos <= (m_pos + 1) % FRAME;
      m_set <= 1'b1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [3:0] es, ec;
    logic       et, er;
    int         d;
    es = '0; ec = '0; et = 1'b0; er = 1'b0; d = 0;
    if (rst_n) begin
      er = m_set && (m_pos != 0);
      et = (m_pos == 0);
      if (m_pos > 0) begin
        d  = (m_pos - 1) / S;
        if ((m_pos - 1) % S >= B) es = 4'(1 << d);
        ec = m_active[d];
      end
    end
    chk("m_sel", digit_sel, es);
    chk("m_tick", frame_tick, et);
    chk("m_ready", wr_ready, er);
    if (m_pos != 0) chk("m_code", digit_code, ec);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] v);
    wr_valid = 1'b1; wr_addr = a; wr_data = v;
    step(1);
    wr_valid = 1'b0;
  endtask

  // Walk from frame position 'from' to the next commit, pinning blank/lit boundaries.
  task automatic show_frame(input logic [15:0] exp, input int from);
    for (int p = from + 1; p <= FRAME; p++) begin
      int d, off;
      step(1);
      if (p == FRAME) begin
        chk("frame_tick", frame_tick, 1);
        chk("commit_ready", wr_ready, 0);
      end else begin
        d   = (p - 1) / S;
        off = (p - 1) % S;
        if (off == B - 1) chk("blank_sel", digit_sel, 0);
        if (off == B || off == S - 1) begin
          chk("lit_sel", digit_sel, 1 << d);
          chk("lit_code", digit_code, exp[d*4 +: 4]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    step(3);
    chk("rst_sel", digit_sel, 0);
    chk("rst_code", digit_code, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_ready", wr_ready, 0);
    rst_n = 1'b1;
    step(1);
    chk("ready_rise", wr_ready, 1);
    chk("no_tick_yet", frame_tick, 0);
    step(1);
    chk("first_commit", frame_tick, 1);
    step(1);
    chk("blank_after_commit", digit_sel, 0);

    // scan order
    enable = 1'b0;
    step(2);
    for (int i = 0; i < N; i++) wr(2'(i), 4'(i + 1));
    enable = 1'b1;
    step(1);
    chk("commit_on_enable", frame_tick, 1);
    show_frame(16'h4321, 0);

    // tear-free update mid-frame
    step(4);
    wr(2'd2, 4'hF);
    show_frame(16'h4321, 5);
    show_frame(16'h4F21, 0);

    // request held across a commit
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'hA;
    chk("ready_low_in_commit", wr_ready, 0);
    step(1);
    chk("ready_after_commit", wr_ready, 1);
    step(1);
    wr_valid = 1'b0;
    show_frame(16'h4F21, 2);
    show_frame(16'h4FA1, 0);

    // enable drop during digit 2
    step(20);
    chk("lit_d2", digit_sel, 4'b0100);
    enable = 1'b0;
    step(1);
    chk("drop_sel", digit_sel, 0);
    chk("drop_code", digit_code, 0);
    step(3);
    enable = 1'b1;
    step(1);
    chk("reenable_commit", frame_tick, 1);
    show_frame(16'h4FA1, 0);

    // asynchronous reset mid-show
    step(20);
    #1 rst_n = 1'b0;
    #1;
    chk("async_sel", digit_sel, 0);
    chk("async_code", digit_code, 0);
    chk("async_ready", wr_ready, 0);
    chk("async_tick", frame_tick, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("ready_after_async", wr_ready, 1);
    step(1);
    chk("commit_after_async", frame_tick, 1);
    show_frame(16'h0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
